// File: rtl/ws_skew_feeder.sv
// ws_skew_feeder: latches tile weights, buffers activation rows and streams them diagonally skewed to a systolic array
module ws_skew_feeder #(
  parameter int SIZE = 8,
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int DEPTH = 32,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [ROW*COL*SIZE-1:0]           w_data,
  input  logic                              act_valid,
  output logic                              act_ready,
  input  logic [ROW*SIZE-1:0]               act_data,
  output logic [ROW*SIZE-1:0]               a_vec,
  output logic [ROW-1:0]                    a_zero,
  output logic [ROW*COL*SIZE-1:0]           b_vec,
  output logic                              b_load,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(DEPTH*ROW+1)-1:0]    zero_count
);
  localparam int TW = $clog2(DEPTH + ROW);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam int ZW = $clog2(DEPTH*ROW + 1);
  typedef enum logic [2:0] {IDLE, WLOAD, FILL, STREAM, DRAIN, DONE} state_t;
  state_t state;
  logic [ROW*SIZE-1:0] buf_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [TW-1:0] t;
  logic [DW-1:0] d;
  logic [ROW*SIZE-1:0] nxt;
  logic [ROW-1:0] nz;
  logic [ZW-1:0] zinc;
  assign busy = state != IDLE;
  assign w_ready = state == WLOAD;
  assign act_ready = state == FILL;
  // skewed pattern for counter t: lane i takes row t-i when that row exists
  always_comb begin
    nxt = '0;
    nz = '0;
    zinc = '0;
    for (int i = 0; i < ROW; i++) begin
      logic [TW-1:0] idx;
      logic win;
      logic [SIZE-1:0] lane;
      idx = t - TW'(i);
      win = (t >= TW'(i)) && (idx < TW'(DEPTH));
      lane = win ? buf_mem[AW'(idx)][SIZE*(ROW-i)-1 -: SIZE] : '0;
      nxt[SIZE*(ROW-i)-1 -: SIZE] = lane;
      nz[i] = lane == '0;
      zinc = zinc + ZW'(win && lane == '0);
    end
  end
  // activation buffer is written only by FILL handshakes
  always_ff @(posedge clk)
    if (state == FILL && act_valid) buf_mem[wr_ptr] <= act_data;
  // tile sequencer with registered array-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_vec <= '0;
      a_zero <= '1;
      b_vec <= '0;
      b_load <= 1'b0;
      done <= 1'b0;
      zero_count <= '0;
      wr_ptr <= '0;
      t <= '0;
      d <= '0;
    end else begin
      b_load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= WLOAD;
          zero_count <= '0;
        end
        WLOAD: if (w_valid) begin
          b_vec <= w_data;
          b_load <= 1'b1;
          state <= FILL;
        end
        FILL: if (act_valid) begin
          wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + AW'(1);
          t <= '0;
          if (wr_ptr == AW'(DEPTH-1)) state <= STREAM;
        end
        STREAM: begin
          a_vec <= nxt;
          a_zero <= nz;
          zero_count <= zero_count + zinc;
          t <= t + TW'(1);
          d <= '0;
          if (t == TW'(DEPTH+ROW-2)) state <= DRAIN;
        end
        DRAIN: begin
          a_vec <= '0;
          a_zero <= '1;
          d <= d + DW'(1);
          if (d == DW'(DRAIN_CYCLES-1)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws_skew_feeder.sv
// tb_ws_skew_feeder: directed checks of weight load, fill, skewed streaming, drain and abort
module tb_ws_skew_feeder;
  logic clk = 0, reset = 1;
  logic start = 0, w_valid = 0, act_valid = 0;
  logic [127:0] w_data = '0;
  logic [31:0] act_data = '0;
  logic w_ready, act_ready, b_load, busy, done;
  logic [31:0] a_vec;
  logic [3:0] a_zero;
  logic [127:0] b_vec;
  logic [4:0] zero_count;
  logic s1 = 0, wv1 = 0, av1 = 0;
  logic [31:0] ad1 = '0;
  logic wr1, ar1, bl1, busy1, done1;
  logic [31:0] a1;
  logic [3:0] az1;
  logic [127:0] b1;
  logic [2:0] zc1;
  int n_chk = 0, n_fail = 0;
  logic [127:0] W = 128'h0102030405060708090a0b0c0d0e0f10;
  logic [31:0] rows [4];
  logic [31:0] rows1 [4] = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334};
  logic [31:0] rows2 [4] = '{32'h01020304, 32'h00000000, 32'h21222324, 32'h31320034};
  logic [31:0] hp [7] = '{32'h01000000, 32'h11020000, 32'h21120300, 32'h31221304,
                          32'h00322314, 32'h00003324, 32'h00000034};
  logic [31:0] hp1 [4] = '{32'h05000000, 32'h00060000, 32'h00000700, 32'h00000008};

  ws_skew_feeder #(.SIZE(8), .ROW(4), .COL(4), .DEPTH(4), .DRAIN_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .start(start), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .a_vec(a_vec), .a_zero(a_zero),
    .b_vec(b_vec), .b_load(b_load), .busy(busy), .done(done), .zero_count(zero_count));
  ws_skew_feeder #(.SIZE(8), .ROW(4), .COL(4), .DEPTH(1), .DRAIN_CYCLES(2)) u1 (
    .clk(clk), .reset(reset), .start(s1), .w_valid(wv1), .w_ready(wr1), .w_data(W),
    .act_valid(av1), .act_ready(ar1), .act_data(ad1), .a_vec(a1), .a_zero(az1),
    .b_vec(b1), .b_load(bl1), .busy(busy1), .done(done1), .zero_count(zc1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] zmask(input logic [31:0] v);
    for (int i = 0; i < 4; i++) zmask[i] = v[8*(4-i)-1 -: 8] == 8'h00;
  endfunction

  function automatic logic [31:0] model(input int k);
    model = '0;
    for (int i = 0; i < 4; i++)
      if (k - i >= 0 && k - i < 4) model[8*(4-i)-1 -: 8] = rows[k-i][8*(4-i)-1 -: 8];
  endfunction

  task automatic run_tile(input bit tog, input bit poke, input logic [4:0] zc_exp, input bit hand);
    int nf;
    logic [31:0] e;
    start = 1;
    tick;
    start = 0;
    check("wload_busy", busy, 1);
    check("w_ready", w_ready, 1);
    check("act_ready_wload", act_ready, 0);
    check("zc_clear", zero_count, 0);
    w_valid = 1;
    w_data = W;
    tick;
    w_valid = 0;
    check("b_vec", b_vec, W);
    check("b_load", b_load, 1);
    nf = 0;
    for (int r = 0; r < 4; r++) begin
      if (tog) begin
        act_valid = 0;
        check("act_ready_gap", act_ready, 1);
        tick;
        nf++;
      end
      act_valid = 1;
      act_data = rows[r];
      check("act_ready", act_ready, 1);
      tick;
      nf++;
      act_valid = 0;
    end
    check("fill_cycles", nf, tog ? 8 : 4);
    check("b_load_once", b_load, 0);
    for (int k = 0; k < 7; k++) begin
      if (poke && k == 2) start = 1;
      tick;
      start = 0;
      e = hand ? hp[k] : model(k);
      check("a_vec", a_vec, e);
      check("a_zero", a_zero, zmask(e));
      check("stream_done", done, 0);
    end
    tick;
    check("drain_a_vec", a_vec, 0);
    check("drain_a_zero", a_zero, 4'hf);
    check("drain_done", done, 0);
    if (poke) start = 1;
    tick;
    check("done", done, 1);
    check("done_busy", busy, 1);
    tick;
    start = 0;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("zero_count", zero_count, zc_exp);
    check("b_vec_hold", b_vec, W);
    tick;
    check("start_ignored", busy, 0);
  endtask

  initial begin
    int nd;
    repeat (3) tick;
    reset = 0;
    check("rst_a_vec", a_vec, 0);
    check("rst_a_zero", a_zero, 4'hf);
    check("rst_b_vec", b_vec, 0);
    check("rst_b_load", b_load, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zc", zero_count, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_act_ready", act_ready, 0);
    rows = rows1;
    run_tile(0, 0, 0, 1);
    rows = rows2;
    run_tile(0, 0, 5, 0);
    rows = rows1;
    run_tile(1, 0, 0, 1);
    rows = rows2;
    run_tile(0, 1, 5, 0);
    start = 1;
    tick;
    start = 0;
    w_valid = 1;
    tick;
    w_valid = 0;
    for (int r = 0; r < 4; r++) begin
      act_valid = 1;
      act_data = rows1[r];
      tick;
    end
    act_valid = 0;
    tick;
    tick;
    reset = 1;
    tick;
    reset = 0;
    check("abort_a_vec", a_vec, 0);
    check("abort_a_zero", a_zero, 4'hf);
    check("abort_busy", busy, 0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      nd += done;
    end
    check("abort_no_done", nd, 0);
    rows = rows1;
    run_tile(0, 0, 0, 1);
    s1 = 1;
    tick;
    s1 = 0;
    wv1 = 1;
    tick;
    wv1 = 0;
    check("d1_b_load", bl1, 1);
    av1 = 1;
    ad1 = 32'h05060708;
    tick;
    av1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("d1_a_vec", a1, hp1[k]);
      check("d1_a_zero", az1, zmask(hp1[k]));
    end
    tick;
    check("d1_drain", a1, 0);
    tick;
    check("d1_done", done1, 1);
    tick;
    check("d1_idle", busy1, 0);
    check("d1_zc", zc1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
